// File: rtl/rr_hold_arbiter_if.sv
// Request/grant bundle between router input channels and one output-port arbiter.
interface rr_hold_arbiter_if #(
    parameter int N = 5
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid
    );
endinterface

// File: rtl/rr_hold_arbiter.sv
// N-input hold arbiter: round-robin or fixed priority, bounded hold, zero-bubble handoff.
module rr_hold_arbiter #(
    parameter int N        = 5,
    parameter int MAX_HOLD = 16,
    parameter bit RR_EN    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    rr_hold_arbiter_if.slave   bus
);
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int HOLD_W = $clog2(MAX_HOLD + 2);
    localparam logic [HOLD_W-1:0] HOLD_SAT =
        HOLD_W'((MAX_HOLD == 0) ? 1 : MAX_HOLD);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e            state_q, state_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              valid_q, valid_d;

    logic [N-1:0]      cand;
    logic [IDX_W-1:0]  win;
    logic              found;
    int                base;
    int                j;

    logic own_req, others, at_lim, preempt, keep, hand;

    // Scan the candidate mask starting at the rotating pointer
    always_comb begin
        found = 1'b0;
        win   = '0;
        j     = 0;
        base  = RR_EN ? int'(ptr_q) : 0;
        for (int k = 0; k < N; k++) begin
            j = (base + k) % N;
            if (!found && cand[j[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = j[IDX_W-1:0];
            end
        end
    end

    assign own_req = |(bus.req & gnt_q);
    assign others  = |(bus.req & ~gnt_q);
    assign at_lim  = (MAX_HOLD != 0) && (hold_q == HOLD_SAT);
    assign preempt = own_req && at_lim && others;
    assign keep    = own_req && !preempt;
    assign hand    = !own_req && (|bus.req);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        cand    = bus.req;
        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                unique case (1'b1)
                    preempt: cand = bus.req & ~gnt_q;
                    keep: begin
                        if (hold_q != HOLD_SAT) hold_d = hold_q + 1'b1;
                    end
                    hand: cand = bus.req;
                    default: begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        idx_d   = '0;
                        hold_d  = '0;
                        valid_d = 1'b0;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
        // Any new owner: from idle, handoff or preempt
        if ((state_q == IDLE && |bus.req) ||
            (state_q == GRANT && (preempt || hand))) begin
            state_d = GRANT;
            gnt_d   = N'(1) << win;
            idx_d   = win;
            hold_d  = HOLD_W'(1);
            valid_d = 1'b1;
            if (RR_EN) begin
                ptr_d = (int'(win) == N - 1) ? '0 : win + 1'b1;
            end else begin
                ptr_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Randomised and directed checks of two arbiter configurations against an owner-level model.
module tb_rr_hold_arbiter;
    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;

    int checks = 0;
    int errors = 0;

    // Model state per config: 0 = RR, limit 4; 1 = fixed, unlimited
    int owner [2];
    int hold  [2];
    int ptr   [2];
    int lim   [2] = '{4, 0};
    bit rr    [2] = '{1'b1, 1'b0};

    rr_hold_arbiter_if #(.N(N)) ifa ();
    rr_hold_arbiter_if #(.N(N)) ifb ();

    assign ifa.req = req;
    assign ifb.req = req;

    rr_hold_arbiter #(.N(N), .MAX_HOLD(4), .RR_EN(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    rr_hold_arbiter #(.N(N), .MAX_HOLD(0), .RR_EN(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input int d, input logic [N-1:0] c);
        int s;
        s = rr[d] ? ptr[d] : 0;
        for (int k = 0; k < N; k++) begin
            if (c[(s + k) % N]) return (s + k) % N;
        end
        return -1;
    endfunction

    task automatic new_owner(input int d, input int w);
        owner[d] = w;
        hold[d]  = 1;
        ptr[d]   = rr[d] ? (w + 1) % N : 0;
    endtask

    task automatic model_step(input int d);
        logic [N-1:0] rest;
        if (rst) begin
            owner[d] = -1;
            hold[d]  = 0;
            ptr[d]   = 0;
        end else if (owner[d] < 0) begin
            if (req != 0) new_owner(d, pick(d, req));
        end else if (req[owner[d]]) begin
            rest = req;
            rest[owner[d]] = 1'b0;
            if (lim[d] > 0 && hold[d] == lim[d] && rest != 0)
                new_owner(d, pick(d, rest));
            else if (lim[d] == 0 || hold[d] < lim[d])
                hold[d]++;
        end else if (req != 0) begin
            new_owner(d, pick(d, req));
        end else begin
            owner[d] = -1;
            hold[d]  = 0;
        end
    endtask

    function automatic logic [31:0] exp_gnt(input int d);
        return (owner[d] < 0) ? 32'd0 : (32'd1 << owner[d]);
    endfunction

    function automatic logic [31:0] exp_idx(input int d);
        return (owner[d] < 0) ? 32'd0 : 32'(owner[d]);
    endfunction

    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        chk("a_gnt", 32'(ifa.gnt), exp_gnt(0));
        chk("a_idx", 32'(ifa.gnt_idx), exp_idx(0));
        chk("a_valid", 32'(ifa.gnt_valid), 32'(owner[0] >= 0));
        chk("b_gnt", 32'(ifb.gnt), exp_gnt(1));
        chk("b_idx", 32'(ifb.gnt_idx), exp_idx(1));
        chk("b_valid", 32'(ifb.gnt_valid), 32'(owner[1] >= 0));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int last;
        int cnt;
        owner = '{-1, -1};
        hold  = '{0, 0};
        ptr   = '{0, 0};

        // Reset held with all requests up
        rst = 1'b1;
        req = 5'b11111;
        steps(2);
        chk("rst_gnt", 32'(ifa.gnt), 32'd0);
        chk("rst_valid", 32'(ifa.gnt_valid), 32'd0);
        rst = 1'b0;
        step();
        chk("rel_gnt", 32'(ifa.gnt), 32'b00001);

        req = '0;
        steps(2);

        // Single request for 4 cycles
        req = 5'b00100;
        steps(4);
        chk("single_gnt", 32'(ifa.gnt), 32'b00100);
        req = '0;
        step();
        chk("single_drop", 32'(ifa.gnt), 32'd0);
        step();

        // Round-robin handoff: owners drop after 2 granted cycles
        req  = 5'b11111;
        last = -1;
        cnt  = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (owner[0] != last) begin
                last = owner[0];
                cnt  = 1;
            end else begin
                cnt++;
            end
            req = 5'b11111;
            if (cnt == 2 && owner[0] >= 0) req[owner[0]] = 1'b0;
        end
        req = '0;
        steps(3);

        // Hold limit on config A, no preemption on config B
        req = 5'b00011;
        steps(4);
        chk("lim_first", 32'(ifa.gnt), 32'b00001);
        step();
        chk("lim_preempt", 32'(ifa.gnt), 32'b00010);
        steps(4);
        chk("lim_back", 32'(ifa.gnt), 32'b00001);
        chk("fixed_hold", 32'(ifb.gnt), 32'b00001);
        req = 5'b00001;
        steps(10);
        chk("lim_alone", 32'(ifa.gnt), 32'b00001);
        req = '0;
        steps(3);

        // Fixed priority from idle, long hold, then handoff
        req = 5'b10110;
        step();
        chk("fixed_first", 32'(ifb.gnt), 32'b00010);
        steps(20);
        chk("fixed_nopre", 32'(ifb.gnt), 32'b00010);
        req = 5'b10100;
        step();
        chk("fixed_hand", 32'(ifb.gnt), 32'b00100);
        req = '0;
        steps(3);

        // Reset mid-grant on owner 3
        req = 5'b01000;
        steps(2);
        rst = 1'b1;
        step();
        chk("midrst_gnt", 32'(ifa.gnt), 32'd0);
        rst = 1'b0;
        step();
        chk("midrst_regnt", 32'(ifa.gnt), 32'b01000);
        chk("midrst_idx", 32'(ifa.gnt_idx), 32'd3);

        // Random request traffic with sticky bits and rare resets
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(3) == 0) req[b] = ~req[b];
            end
            rst = ($urandom_range(199) == 0);
            step();
        end
        rst = 1'b0;
        req = '0;
        steps(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
